instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue_pkg.sv | 32 +++
 rtl/inst_field_decode.sv | 36 +++
 rtl/instruction_queue.sv | 138 +++++++++++++
 tb/tb_instruction_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// ============================================================================
// Module : instruction_queue_pkg
// Brief  : Shared field positions, default NOP word and queue-operation
//          encoding for the instruction queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_queue_pkg;

    // Field layout: the opcode occupies the top C_OPCODE_W bits. Operand
    // addresses sit directly below it, and the immediate starts at bit 0.
    localparam int C_OPCODE_W   = 4;
    localparam int C_ADDR_A_OFS = C_OPCODE_W;
    localparam int C_IMM_LSB    = 0;

    localparam logic [255:0] C_NOP_INST = '0;

    typedef enum logic [1:0] {
        Q_IDLE     = 2'd0,
        Q_PUSH     = 2'd1,
        Q_POP      = 2'd2,
        Q_PUSH_POP = 2'd3
    } queue_op_e;

    function automatic queue_op_e queue_op(input logic push, input logic pop);
        return queue_op_e'({pop, push});
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_field_decode.sv
// ============================================================================
// Module : inst_field_decode
// Brief  : Pure field slicing of an instruction word into operand fields.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_field_decode
    import instruction_queue_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic [INST_W-1:0] inst,
    output logic [IMM_W-1:0]  imm,
    output logic [IMM_W-1:0]  displacement,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b
);

    localparam int C_ADDR_A_MSB = INST_W - 1 - C_ADDR_A_OFS;
    localparam int C_ADDR_B_MSB = C_ADDR_A_MSB - ADDR_W;

    // Opcode bits are decoded further down the pipe, not here.
    logic w_unused_bits;
    assign w_unused_bits = ^inst;

    assign imm          = inst[C_IMM_LSB +: IMM_W];
    assign displacement = inst[C_IMM_LSB +: IMM_W];
    assign addr_a       = inst[C_ADDR_A_MSB -: ADDR_W];
    assign addr_b       = inst[C_ADDR_B_MSB -: ADDR_W];

endmodule

`default_nettype wire

// File: rtl/instruction_queue.sv
// ============================================================================
// Module : instruction_queue
// Brief  : Flushable fetch-to-decode instruction FIFO with head-field decode.
//          Define INSTQ_BYPASS_EN for fall-through when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 4,
    parameter int                IMM_W    = 8,
    parameter logic [INST_W-1:0] NOP_INST = C_NOP_INST[INST_W-1:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       jump_i,
    input  logic                       branch_i,
    input  logic                       in_valid_i,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [IMM_W-1:0]           imm_o,
    output logic [IMM_W-1:0]           displacement_o,
    output logic [ADDR_W-1:0]          addr_a_o,
    output logic [ADDR_W-1:0]          addr_b_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_flush;
    logic              w_empty;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic              w_rd;
    logic [INST_W-1:0] w_head;
    queue_op_e         w_op;

    assign w_flush = jump_i | branch_i;
    assign w_empty = (r_count == '0);

`ifdef INSTQ_BYPASS_EN
    // Reset gates fall-through so outputs stay idle while rst_i is low.
    assign w_bypass = rst_i & w_empty & in_valid_i & ~w_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready_o  = (r_count < C_DEPTH);
    assign out_valid_o = ~w_empty | w_bypass;
    assign count_o     = r_count;

    assign w_push = in_valid_i & in_ready_o & ~w_flush;
    assign w_pop  = out_valid_o & out_ready_i & ~w_flush;

    // A fall-through word consumed in the same cycle never touches storage.
    assign w_wr = w_push & ~(w_bypass & w_pop);
    assign w_rd = w_pop & ~w_bypass;
    assign w_op = queue_op(w_wr, w_rd);

    always_comb begin
        w_head = w_empty ? NOP_INST : r_mem[r_head];
`ifdef INSTQ_BYPASS_EN
        if (w_bypass) begin
            w_head = inst_i;
        end
`endif
    end

    assign inst_o = w_head;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_tail] <= inst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case (w_op)
                Q_PUSH: begin
                    r_tail  <= r_tail + 1'b1;
                    r_count <= r_count + C_ONE;
                end
                Q_POP: begin
                    r_head  <= r_head + 1'b1;
                    r_count <= r_count - C_ONE;
                end
                Q_PUSH_POP: begin
                    r_tail  <= r_tail + 1'b1;
                    r_head  <= r_head + 1'b1;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    inst_field_decode #(
        .INST_W (INST_W),
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .inst         (w_head),
        .imm          (imm_o),
        .displacement (displacement_o),
        .addr_a       (addr_a_o),
        .addr_b       (addr_b_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_queue.sv
// ============================================================================
// Module : tb_instruction_queue
// Brief  : Directed scoreboard bench for instruction_queue (default params).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_queue;

    logic        clk;
    logic        rst_n;
    logic        jump;
    logic        branch;
    logic        in_valid;
    logic [15:0] inst_in;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] inst_out;
    logic [7:0]  imm;
    logic [7:0]  disp;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [2:0]  count;

    instruction_queue dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .jump_i         (jump),
        .branch_i       (branch),
        .in_valid_i     (in_valid),
        .inst_i         (inst_in),
        .in_ready_o     (in_ready),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .inst_o         (inst_out),
        .imm_o          (imm),
        .displacement_o (disp),
        .addr_a_o       (addr_a),
        .addr_b_o       (addr_b),
        .count_o        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cnt;
        bit          vld;
        bit          rdy;
        logic [15:0] inst;
        bit          drain;
    } stat_t;

    stat_t       stat_q[$];
    logic [15:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: scoreboard pops on every consumed head, then status requests.
    always @(negedge clk) begin
        stat_t       st;
        logic [15:0] w;
        if (rst_n && out_valid && out_ready && !jump && !branch) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no output", inst_out);
            end else begin
                w = exp_q.pop_front();
                chk("pop_order", {16'h0, inst_out}, {16'h0, w});
            end
        end
        while (stat_q.size() > 0) begin
            st = stat_q.pop_front();
            chk({st.name, "_count"},  {29'h0, count},     st.cnt);
            chk({st.name, "_valid"},  {31'h0, out_valid}, {31'h0, st.vld});
            chk({st.name, "_ready"},  {31'h0, in_ready},  {31'h0, st.rdy});
            chk({st.name, "_inst"},   {16'h0, inst_out},  {16'h0, st.inst});
            chk({st.name, "_addr_a"}, {28'h0, addr_a},    {28'h0, st.inst[11:8]});
            chk({st.name, "_addr_b"}, {28'h0, addr_b},    {28'h0, st.inst[7:4]});
            chk({st.name, "_imm"},    {24'h0, imm},       {24'h0, st.inst[7:0]});
            chk({st.name, "_disp"},   {24'h0, disp},      {24'h0, st.inst[7:0]});
            if (st.drain) chk({st.name, "_scoreboard_empty"}, exp_q.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input string nm, input int cnt, input bit vld,
                                 input bit rdy, input logic [15:0] inst, input bit drain);
        stat_t st;
        st.name  = nm;
        st.cnt   = cnt;
        st.vld   = vld;
        st.rdy   = rdy;
        st.inst  = inst;
        st.drain = drain;
        stat_q.push_back(st);
    endtask

    task automatic push_word(input logic [15:0] w);
        in_valid = 1'b1;
        inst_in  = w;
        step();
        in_valid = 1'b0;
    endtask

    logic [15:0] fill [4];
    logic [15:0] seq  [12];

    initial begin
        fill = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        rst_n = 1'b0; jump = 1'b0; branch = 1'b0;
        in_valid = 1'b0; inst_in = 16'h0; out_ready = 1'b0;
        expect_status("reset", 0, 0, 1, 16'h0000, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Fill to capacity, then a fifth word must be refused.
        for (int i = 0; i < 4; i++) push_word(fill[i]);
        in_valid = 1'b1;
        inst_in  = 16'h5555;
        expect_status("full", 4, 1, 0, 16'h1234, 0);
        step();
        in_valid = 1'b0;
        expect_status("fifth_dropped", 4, 1, 0, 16'h1234, 0);
        step();

        for (int i = 0; i < 4; i++) exp_q.push_back(fill[i]);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        expect_status("drained", 0, 0, 1, 16'h0000, 1);
        step();

        // Branch flush with a colliding push and pop.
        push_word(16'h1111);
        push_word(16'h2222);
        branch    = 1'b1;
        in_valid  = 1'b1;
        inst_in   = 16'hAAAA;
        out_ready = 1'b1;
        step();
        branch   = 1'b0;
        in_valid = 1'b0;
        expect_status("branch_flush", 0, 0, 1, 16'h0000, 0);
        step(); step();
        out_ready = 1'b0;

        push_word(16'h3333);
        jump = 1'b1;
        step();
        jump = 1'b0;
        expect_status("jump_flush", 0, 0, 1, 16'h0000, 1);
        step();

        // Steady push+pop at occupancy 2 across several pointer wraps.
        seq[0] = 16'h0101;
        seq[1] = 16'h0202;
        for (int i = 0; i < 10; i++) seq[i+2] = 16'hC000 + 16'(i);
        push_word(seq[0]);
        push_word(seq[1]);
        exp_q.push_back(seq[0]);
        exp_q.push_back(seq[1]);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            inst_in   = seq[i+2];
            out_ready = 1'b1;
            exp_q.push_back(seq[i+2]);
            expect_status($sformatf("wrap%0d", i), 2, 1, 1, seq[i], 0);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;
        expect_status("wrap_drained", 0, 0, 1, 16'h0000, 1);
        step();

`ifdef INSTQ_BYPASS_EN
        in_valid  = 1'b1;
        inst_in   = 16'h4321;
        out_ready = 1'b1;
        exp_q.push_back(16'h4321);
        expect_status("bypass", 0, 1, 1, 16'h4321, 0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expect_status("bypass_after", 0, 0, 1, 16'h0000, 1);
        step();
`else
        in_valid = 1'b1;
        inst_in  = 16'h4321;
        expect_status("no_fallthrough", 0, 0, 1, 16'h0000, 0);
        step();
        in_valid = 1'b0;
        expect_status("latency1", 1, 1, 1, 16'h4321, 0);
        exp_q.push_back(16'h4321);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_status("latency1_after", 0, 0, 1, 16'h0000, 1);
        step();
`endif

        // Asynchronous reset mid-operation must empty the queue at once.
        push_word(16'h7777);
        push_word(16'h8888);
        expect_status("pre_reset", 2, 1, 1, 16'h7777, 0);
        step();
        #2;
        rst_n = 1'b0;
        expect_status("async_reset", 0, 0, 1, 16'h0000, 1);
        step();
        rst_n = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
